// File: rtl/rr_arb_idx4.sv
// rr_arb_idx4: 4-requester round-robin arbiter with registered grant index/enable for a 2-to-4 one-hot decoder.
// Optional macro ARB_PRIO0_EN: requester 0 wins whenever requesting and does not advance the pointer.
module rr_arb_idx4 #(
   parameter int HOLD_W   = 4,
   parameter int HOLD_MAX = 15
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic [3:0]        i_req,
   input  logic              i_release,
   output logic [1:0]        o_grant_idx,
   output logic              o_grant_en,
   output logic [HOLD_W-1:0] o_hold_cnt
);
   localparam logic IDLE  = 1'b0;
   localparam logic GRANT = 1'b1;
   logic              r_state;
   logic [1:0]        r_idx;
   logic [1:0]        r_ptr;
   logic [HOLD_W-1:0] r_cnt;
   logic [3:0]        w_rot;
   logic [1:0]        w_off;
   logic [1:0]        w_win;
   logic [1:0]        w_ptr_nxt;
   logic              w_end;
   // w_rot[k] is the request of requester ptr+k, so the first set bit is the winner offset
   always_comb begin
      w_rot = 4'({i_req, i_req} >> r_ptr);
      w_off = w_rot[0] ? 2'd0 : w_rot[1] ? 2'd1 : w_rot[2] ? 2'd2 : 2'd3;
`ifdef ARB_PRIO0_EN
      w_win     = i_req[0] ? 2'd0 : r_ptr + w_off;
      w_ptr_nxt = (r_idx == 2'd0) ? r_ptr : r_idx + 2'd1;
`else
      w_win     = r_ptr + w_off;
      w_ptr_nxt = r_idx + 2'd1;
`endif
      w_end = i_release | ~i_req[r_idx] | (r_cnt == HOLD_W'(HOLD_MAX));
   end
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_state <= IDLE;
         r_idx   <= 2'd0;
         r_ptr   <= 2'd0;
         r_cnt   <= '0;
      end else if (r_state == IDLE) begin
         if (|i_req) begin
            r_state <= GRANT;
            r_idx   <= w_win;
            r_cnt   <= '0;
         end
      end else if (w_end) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_ptr   <= w_ptr_nxt;
      end else begin
         r_cnt <= r_cnt + HOLD_W'(1);
      end
   end
   assign o_grant_en  = r_state;
   assign o_grant_idx = r_idx;
   assign o_hold_cnt  = r_cnt;
endmodule

// File: tb/tb_rr_arb_idx4.sv
// tb_rr_arb_idx4: directed scoreboard bench for rr_arb_idx4; a reference model queues the expected
// {grant_en, grant_idx, hold_cnt} for each stimulus step, compared one cycle later.
module tb_rr_arb_idx4;
   localparam int HOLD_W   = 4;
   localparam int HOLD_MAX = 15;
   logic              clk = 1'b0;
   logic              rst_n;
   logic [3:0]        req;
   logic              rel;
   logic [1:0]        grant_idx;
   logic              grant_en;
   logic [HOLD_W-1:0] hold_cnt;
   int checks = 0;
   int errors = 0;
   logic              m_en;
   logic [1:0]        m_idx;
   logic [1:0]        m_ptr;
   int                m_cnt;
   logic [6:0]        sb[$];
   int                high_cycles;
   logic [1:0]        seq[$];

   rr_arb_idx4 #(.HOLD_W(HOLD_W), .HOLD_MAX(HOLD_MAX)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_req(req), .i_release(rel),
      .o_grant_idx(grant_idx), .o_grant_en(grant_en), .o_hold_cnt(hold_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [6:0] obs, input logic [6:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed en/idx/cnt=%b/%0d/%0d expected %b/%0d/%0d",
                tag, obs[6], obs[5:4], obs[3:0], exp[6], exp[5:4], exp[3:0]);
      end
   endtask

   // Model predicts the post-edge outputs from the inputs presented in this cycle
   task automatic step(input string tag, input logic [3:0] r, input logic rl, input logic rn);
      logic [6:0] exp;
      logic [1:0] cand;
      req = r; rel = rl; rst_n = rn;
      if (!rn) begin
         m_en = 0; m_idx = 0; m_ptr = 0; m_cnt = 0;
      end else if (!m_en) begin
         if (r != 4'b0) begin
            m_idx = 2'd0;
            for (int k = 3; k >= 0; k--) begin
               cand = m_ptr + 2'(k);
               if (r[cand]) m_idx = cand;
            end
`ifdef ARB_PRIO0_EN
            if (r[0]) m_idx = 2'd0;
`endif
            m_en = 1; m_cnt = 0;
         end
      end else if (rl || !r[m_idx] || m_cnt == HOLD_MAX) begin
         m_en = 0; m_cnt = 0;
`ifdef ARB_PRIO0_EN
         if (m_idx != 2'd0) m_ptr = m_idx + 2'd1;
`else
         m_ptr = m_idx + 2'd1;
`endif
      end else begin
         m_cnt = (m_cnt == HOLD_MAX) ? m_cnt : m_cnt + 1;
      end
      sb.push_back({m_en, m_idx, 4'(m_cnt)});
      @(posedge clk);
      #1;
      exp = sb.pop_front();
      check(tag, {grant_en, grant_idx, hold_cnt}, exp);
   endtask

   initial begin
      req = 0; rel = 0; rst_n = 0;
      m_en = 0; m_idx = 0; m_ptr = 0; m_cnt = 0;
      @(negedge clk);
      step("reset0", 4'b0000, 0, 0);
      step("reset1", 4'b1111, 1, 0);
      step("idle_noreq", 4'b0000, 0, 1);
      // single request, count, release
      step("single_grant", 4'b0100, 0, 1);
      for (int i = 0; i < 3; i++) step("single_hold", 4'b0100, 0, 1);
      step("single_release", 4'b0100, 1, 1);
      step("gap_then_idle", 4'b0000, 0, 1);
      // reset mid-grant at hold_cnt 5
      step("rst_grant", 4'b0100, 0, 1);
      for (int i = 0; i < 5; i++) step("rst_hold", 4'b0100, 0, 1);
      check("rst_cnt5", {grant_en, grant_idx, hold_cnt}, {1'b1, 2'd2, 4'd5});
      step("rst_mid", 4'b0100, 0, 0);
      check("rst_zero", {grant_en, grant_idx, hold_cnt}, 7'd0);
      step("rst_regrant", 4'b0100, 0, 1);
      step("rst_release", 4'b0100, 1, 1);
      step("rst_reset", 4'b0000, 0, 0);
      // full rotation
      for (int g = 0; g < 5; g++) begin
         step("rot_grant", 4'b1111, 0, 1);
         seq.push_back(grant_idx);
         step("rot_hold", 4'b1111, 0, 1);
         step("rot_release", 4'b1111, 1, 1);
         check("rot_gap", {grant_en, 6'd0}, 7'd0);
      end
      for (int g = 0; g < 5; g++)
         check("rot_order", {1'b1, seq[g], 4'd0}, {1'b1, 2'(g % 4), 4'd0});
      // hold limit forced revocation
      high_cycles = 0;
      for (int i = 0; i < 17; i++) begin
         step("hold_run", 4'b0010, 0, 1);
         if (grant_en) high_cycles++;
      end
      check("hold_16cyc", 7'(high_cycles), 7'd16);
      step("hold_regrant", 4'b0010, 0, 1);
      check("hold_regrant1", {grant_en, grant_idx, hold_cnt}, {1'b1, 2'd1, 4'd0});
      step("hold_release", 4'b0010, 1, 1);
      // other requesters' changes during a grant are ignored
      step("chg_grant", 4'b0100, 0, 1);
      step("chg_others", 4'b1111, 0, 1);
      step("chg_others2", 4'b0101, 0, 1);
      step("chg_release", 4'b0000, 1, 1);
      // request drop by owner 3 with wrap to 0
      step("drop_grant3", 4'b1000, 0, 1);
      check("drop_is3", {grant_en, grant_idx, 4'd0}, {1'b1, 2'd3, 4'd0});
      step("drop_fall", 4'b0001, 0, 1);
      step("idle_release_ignored", 4'b0000, 1, 1);
      step("wrap_grant0", 4'b0011, 0, 1);
      check("wrap_is0", {grant_en, grant_idx, 4'd0}, {1'b1, 2'd0, 4'd0});
      step("wrap_release", 4'b0011, 1, 1);
      step("wrap_next1", 4'b0011, 0, 1);
      step("wrap_release2", 4'b0000, 1, 1);
`ifdef ARB_PRIO0_EN
      step("p0_reset", 4'b0000, 0, 0);
      step("p0_g1", 4'b0010, 0, 1);
      step("p0_r1", 4'b0010, 1, 1);
      step("p0_first", 4'b1101, 0, 1);
      check("p0_is0", {grant_en, grant_idx, 4'd0}, {1'b1, 2'd0, 4'd0});
      step("p0_rel", 4'b1101, 1, 1);
      step("p0_again", 4'b1101, 0, 1);
      step("p0_rel2", 4'b1101, 1, 1);
      step("p0_drop0", 4'b1100, 0, 1);
      check("p0_is2", {grant_en, grant_idx, 4'd0}, {1'b1, 2'd2, 4'd0});
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
